// File: rtl/cdc_fifo_reader_pkg.sv
// Shared defaults for the cdc_fifo read-side consumer.
// Width-dependent types stay local to the module because they follow its parameters.
package cdc_fifo_reader_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH      = 4;

endpackage

// File: rtl/cdc_fifo_reader.sv
// Read-side consumer for cdc_fifo: converts the pre-ack rd/rd_ack protocol into a
// valid/ready stream through a small register buffer with a zero-latency head.
module cdc_fifo_reader
  import cdc_fifo_reader_pkg::*;
#(
  parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
  parameter int unsigned depth      = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [data_width-1:0]        fifo_rd_data,
  input  logic                         fifo_rd,
  output logic                         fifo_rd_ack,
  output logic [data_width-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(depth+1)-1:0]   level
);

  localparam int unsigned CW = $clog2(depth + 1);
  localparam int unsigned PW = $clog2(depth);

  typedef logic [data_width-1:0] data_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef logic [CW-1:0]         count_t;

  data_t  r_mem [depth];
  ptr_t   r_wr_ptr;
  ptr_t   r_rd_ptr;
  count_t r_count;
  logic   r_ack_q;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [CW:0] w_ack_sum;

  // Non-power-of-two depths need an explicit wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // A presented word is ours only if we acked it on the previous edge.
  always_comb begin
    w_accept    = fifo_rd & r_ack_q;
    w_push      = w_accept;
    w_pop       = m_valid & m_ready;
    w_ack_sum   = {1'b0, r_count} + (CW+1)'(w_accept);
    fifo_rd_ack = ~reset & (w_ack_sum < (CW+1)'(depth));
  end

  always_comb begin
    m_valid = (r_count != '0);
    m_data  = r_mem[r_rd_ptr];
    level   = r_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ack_q  <= 1'b0;
    end else begin
      r_ack_q <= fifo_rd_ack;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is a plain register array so the head can be read combinationally.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= fifo_rd_data;
  end

  // The ack rule reserves a slot for every committed word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && (r_count == CW'(depth)) && !w_pop))
        else $error("cdc_fifo_reader overflow");
    end
  end

endmodule
